// File: rtl/out_channel_checker.sv
// Checks the executor's out-channel stream against a preloaded table of
// expected words. Words go through a small FIFO. One word is popped and
// compared per cycle. The first mismatch is kept for debug.
module out_channel_checker #(
  parameter int WIDTH   = 12,
  parameter int DEPTH   = 8,
  parameter int NEXPECT = 32,
  parameter int EW      = $clog2(NEXPECT)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     program_done,
  input  logic                     out_valid,
  output logic                     out_ready,
  input  logic [WIDTH-1:0]         out_data,
  input  logic                     exp_we,
  input  logic [EW-1:0]            exp_addr,
  input  logic [WIDTH-1:0]         exp_data,
  input  logic [EW:0]              exp_count,
  output logic                     finished,
  output logic                     success,
  output logic [EW:0]              checked,
  output logic                     mismatch,
  output logic [EW:0]              mismatch_index,
  output logic [WIDTH-1:0]         mismatch_got,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [EW:0] NEXP_MAX = (EW+1)'(NEXPECT);
  localparam logic [LW-1:0] FULL   = LW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        state;
  logic [EW:0]       n_exp;
  logic              done_q;
  logic [AW-1:0]     wptr, rptr;
  logic [WIDTH-1:0]  fifo_mem [DEPTH];
  logic [WIDTH-1:0]  tbl      [NEXPECT];

  logic              in_check, push, pop, bad;
  logic [WIDTH-1:0]  word;
  logic [EW:0]       n_exp_in;

  // Handshake, pop and compare decisions for the current cycle.
  always_comb begin
    in_check  = (state == S_CHECK);
    // Full is judged on the registered level only. A pop in the same cycle
    // does not reopen the FIFO.
    out_ready = in_check && (fifo_level != FULL);
    push      = out_valid && out_ready;
    pop       = in_check && (fifo_level != '0);
    word      = fifo_mem[rptr];
    // A word beyond the expected count is an error. This also keeps the
    // table index in range.
    bad       = (checked >= n_exp) || (word != tbl[checked[EW-1:0]]);
    n_exp_in  = (exp_count > NEXP_MAX) ? NEXP_MAX : exp_count;
    finished  = (state == S_DONE);
    success   = finished && !mismatch && (checked == n_exp);
  end

  // Expected table. It has no reset, so a loaded table survives an abort.
  always_ff @(posedge clock) begin
    if (exp_we && (state != S_CHECK) && (32'(exp_addr) < NEXPECT))
      tbl[exp_addr] <= exp_data;
  end

  // FIFO storage. No reset is needed because the pointers gate every read.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wptr] <= out_data;
  end

  // Run control, FIFO pointers, compare results and the done latch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      n_exp          <= '0;
      done_q         <= 1'b0;
      wptr           <= '0;
      rptr           <= '0;
      fifo_level     <= '0;
      checked        <= '0;
      mismatch       <= 1'b0;
      mismatch_index <= '0;
      mismatch_got   <= '0;
    end else begin
      case (state)
        S_CHECK: begin
          if (push) wptr <= wptr + AW'(1);
          if (pop)  rptr <= rptr + AW'(1);
          fifo_level <= fifo_level + LW'(push) - LW'(pop);
          if (pop) begin
            if (checked != '1) checked <= checked + (EW+1)'(1);
            if (bad && !mismatch) begin
              mismatch       <= 1'b1;
              mismatch_index <= checked;
              mismatch_got   <= word;
            end
          end
          if (program_done) done_q <= 1'b1;
          if (done_q && (fifo_level == '0) && !push) state <= S_DONE;
        end
        default: begin
          if (start) begin
            state          <= S_CHECK;
            n_exp          <= n_exp_in;
            done_q         <= 1'b0;
            wptr           <= '0;
            rptr           <= '0;
            fifo_level     <= '0;
            checked        <= '0;
            mismatch       <= 1'b0;
            mismatch_index <= '0;
            mismatch_got   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_channel_checker.sv
// Directed and randomized runs of out_channel_checker. Each run's results
// are compared against a list-level model of the expected-table check.
module tb_out_channel_checker;

  localparam int WIDTH   = 12;
  localparam int DEPTH   = 8;
  localparam int NEXPECT = 32;
  localparam int EW      = $clog2(NEXPECT);
  localparam int SATMAX  = (1 << (EW+1)) - 1;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   start = 1'b0;
  logic                   program_done = 1'b0;
  logic                   out_valid = 1'b0;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data = '0;
  logic                   exp_we = 1'b0;
  logic [EW-1:0]          exp_addr = '0;
  logic [WIDTH-1:0]       exp_data = '0;
  logic [EW:0]            exp_count = '0;
  logic                   finished, success, mismatch;
  logic [EW:0]            checked, mismatch_index;
  logic [WIDTH-1:0]       mismatch_got;
  logic [$clog2(DEPTH):0] fifo_level;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] mtbl [NEXPECT];
  logic [WIDTH-1:0] wq [$];
  int pat [12];

  out_channel_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NEXPECT(NEXPECT)) dut (
    .clock(clock), .reset(reset), .start(start), .program_done(program_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
    .exp_count(exp_count), .finished(finished), .success(success),
    .checked(checked), .mismatch(mismatch), .mismatch_index(mismatch_index),
    .mismatch_got(mismatch_got), .fifo_level(fifo_level)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(out_ready), 0);
    chk({tag, "_fin"},   32'(finished), 0);
    chk({tag, "_succ"},  32'(success), 0);
    chk({tag, "_chk"},   32'(checked), 0);
    chk({tag, "_mm"},    32'(mismatch), 0);
    chk({tag, "_mmi"},   32'(mismatch_index), 0);
    chk({tag, "_mmg"},   32'(mismatch_got), 0);
    chk({tag, "_lvl"},   32'(fifo_level), 0);
  endtask

  task automatic write_entry(input int a, input logic [WIDTH-1:0] d);
    exp_we = 1'b1; exp_addr = EW'(a); exp_data = d;
    step();
    exp_we = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < NEXPECT; i++) write_entry(i, mtbl[i]);
  endtask

  task automatic set_pattern();
    wq.delete();
    foreach (pat[i]) wq.push_back(WIDTH'(pat[i]));
  endtask

  task automatic start_run(input int cnt);
    exp_count = (EW+1)'(cnt);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // One complete run. It starts, streams wq, pulses program_done, waits for
  // finished and then checks the results against the model.
  task automatic do_run(input int cnt, input bit gaps, input bit chk_lat, input string tag);
    int cyc, maxlvl, ne, mi, echk;
    logic [WIDTH-1:0] mg;
    start_run(cnt);
    chk({tag, "_fin_after_start"}, 32'(finished), 0);
    chk({tag, "_chk_after_start"}, 32'(checked), 0);
    maxlvl = 0;
    foreach (wq[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        out_valid = 1'b0;
        step();
      end
      out_valid = 1'b1;
      out_data  = wq[i];
      chk({tag, "_ready_fin"}, {30'd0, out_ready, finished}, 32'd2);
      step();
      if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
    end
    out_valid = 1'b0;
    program_done = 1'b1;
    step();
    program_done = 1'b0;
    cyc = 1;
    while (finished !== 1'b1 && cyc < 50) begin
      step();
      cyc++;
    end
    chk({tag, "_finished"}, 32'(finished), 1);
    if (chk_lat) chk({tag, "_latency_le2"}, 32'(cyc <= 2), 1);
    chk({tag, "_maxlvl_le1"}, 32'(maxlvl <= 1), 1);

    // Model: the first out-of-range or unequal word is the mismatch, and
    // checked is the saturated word count.
    ne = (cnt > NEXPECT) ? NEXPECT : cnt;
    mi = -1;
    mg = '0;
    for (int i = 0; i < wq.size(); i++) begin
      if (i >= ne || wq[i] != mtbl[i]) begin
        mi = i; mg = wq[i];
        break;
      end
    end
    echk = (wq.size() > SATMAX) ? SATMAX : wq.size();
    chk({tag, "_success"}, 32'(success), 32'(mi < 0 && wq.size() == ne));
    chk({tag, "_checked"}, 32'(checked), 32'(echk));
    chk({tag, "_mismatch"}, 32'(mismatch), 32'(mi >= 0));
    chk({tag, "_mm_index"}, 32'(mismatch_index), 32'(mi < 0 ? 0 : mi));
    chk({tag, "_mm_got"}, 32'(mismatch_got), 32'(mg));
  endtask

  initial begin
    pat = '{3, 2, 1, 0, 3, 2, 1, 0, 0, 1, 2, 3};
    for (int i = 0; i < NEXPECT; i++) mtbl[i] = WIDTH'($urandom);
    foreach (pat[i]) mtbl[i] = WIDTH'(pat[i]);

    step(); step();
    chk_reset("reset_state");
    reset = 1'b0;
    step();

    load_all();

    set_pattern();
    do_run(12, 1'b0, 1'b1, "match12");

    set_pattern();
    wq[5] = 12'd7; wq[11] = 12'd9;
    do_run(12, 1'b0, 1'b1, "mis_at5");

    set_pattern();
    void'(wq.pop_back());
    do_run(12, 1'b0, 1'b0, "short11");

    set_pattern();
    wq.push_back(12'd4);
    do_run(12, 1'b0, 1'b0, "excess13");

    // Abort with reset after 5 words. Outputs must clear before the next edge.
    start_run(12);
    for (int i = 0; i < 5; i++) begin
      out_valid = 1'b1; out_data = WIDTH'(pat[i]);
      step();
    end
    out_valid = 1'b0;
    #3 reset = 1'b1;
    #1 chk_reset("async_reset");
    step();
    reset = 1'b0;
    set_pattern();
    do_run(12, 1'b0, 1'b1, "after_reset");

    // Reload entry 0 while DONE, then rerun with the old first word.
    write_entry(0, 12'd4);
    mtbl[0] = 12'd4;
    set_pattern();
    do_run(12, 1'b0, 1'b0, "reload0");

    wq.delete();
    do_run(0, 1'b0, 1'b0, "empty");

    // exp_count above capacity is clamped to NEXPECT.
    wq.delete();
    for (int i = 0; i < NEXPECT; i++) wq.push_back(mtbl[i]);
    do_run(40, 1'b0, 1'b0, "clamp_ok");
    wq.push_back(12'd5);
    do_run(40, 1'b0, 1'b0, "clamp_excess");

    // Random tables, counts, corruptions and valid gaps.
    for (int r = 0; r < 8; r++) begin
      int cnt, len;
      for (int i = 0; i < NEXPECT; i++) mtbl[i] = WIDTH'($urandom);
      load_all();
      cnt = $urandom_range(0, NEXPECT + 3);
      len = $urandom_range(0, NEXPECT + 4);
      wq.delete();
      for (int i = 0; i < len; i++) begin
        logic [WIDTH-1:0] w;
        w = (i < NEXPECT) ? mtbl[i] : WIDTH'($urandom);
        if ($urandom_range(0, 15) == 0) w = w ^ WIDTH'($urandom_range(1, 4095));
        wq.push_back(w);
      end
      do_run(cnt, 1'b1, 1'b0, $sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
